// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute ALU with a valid/ready handshake.
// Single-cycle ops (ADD..SLTU, reserved) complete one cycle after accept.
// Iterative ops (MUL, MULHU, DIVU, REMU) use a shared shift-add / restoring
// datapath, one bit per cycle. That datapath is present only when the macro
// ALU_MULDIV_EN is defined; otherwise B-E behave like the reserved opcode.
module alu_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     flush_i,
    input  logic [CONTROL_WIDTH-1:0] ALUctrl_i,
    input  logic [DATA_WIDTH-1:0]    SrcA_i,
    input  logic [DATA_WIDTH-1:0]    SrcB_i,
    output logic                     valid_o,
    output logic [DATA_WIDTH-1:0]    ALUResult_o,
    output logic                     Zero_o
);

    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [CONTROL_WIDTH-1:0] OP_ADD   = 4'h0;
    localparam logic [CONTROL_WIDTH-1:0] OP_SUB   = 4'h1;
    localparam logic [CONTROL_WIDTH-1:0] OP_AND   = 4'h2;
    localparam logic [CONTROL_WIDTH-1:0] OP_OR    = 4'h3;
    localparam logic [CONTROL_WIDTH-1:0] OP_XOR   = 4'h4;
    localparam logic [CONTROL_WIDTH-1:0] OP_SLL   = 4'h5;
    localparam logic [CONTROL_WIDTH-1:0] OP_SRL   = 4'h6;
    localparam logic [CONTROL_WIDTH-1:0] OP_PASSB = 4'h7;
    localparam logic [CONTROL_WIDTH-1:0] OP_SRA   = 4'h8;
    localparam logic [CONTROL_WIDTH-1:0] OP_SLT   = 4'h9;
    localparam logic [CONTROL_WIDTH-1:0] OP_SLTU  = 4'hA;
    localparam logic [CONTROL_WIDTH-1:0] OP_MUL   = 4'hB;
    localparam logic [CONTROL_WIDTH-1:0] OP_MULHU = 4'hC;
    localparam logic [CONTROL_WIDTH-1:0] OP_DIVU  = 4'hD;
    localparam logic [CONTROL_WIDTH-1:0] OP_REMU  = 4'hE;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    zero_q;
    logic                    accept;
    logic                    iter_op;

    // Single-cycle result; B-F fall to zero here.
    function automatic logic [DATA_WIDTH-1:0] alu_comb(
        input logic [CONTROL_WIDTH-1:0] op,
        input logic [DATA_WIDTH-1:0]    a,
        input logic [DATA_WIDTH-1:0]    b
    );
        logic signed [DATA_WIDTH-1:0] sa;
        logic signed [DATA_WIDTH-1:0] sb;
        logic [SHW-1:0]               sh;
        sa = a;
        sb = b;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:   alu_comb = a + b;
            OP_SUB:   alu_comb = a - b;
            OP_AND:   alu_comb = a & b;
            OP_OR:    alu_comb = a | b;
            OP_XOR:   alu_comb = a ^ b;
            OP_SLL:   alu_comb = a << sh;
            OP_SRL:   alu_comb = a >> sh;
            OP_PASSB: alu_comb = b;
            OP_SRA:   alu_comb = $unsigned(sa >>> sh);
            OP_SLT:   alu_comb = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU:  alu_comb = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            default:  alu_comb = '0;
        endcase
    endfunction

    assign ready_o     = (state_q != BUSY);
    assign accept      = valid_i & ready_o;
    assign valid_o     = valid_q;
    assign ALUResult_o = result_q;
    assign Zero_o      = zero_q;

`ifdef ALU_MULDIV_EN
    localparam int CW = $clog2(DATA_WIDTH);

    logic [CW-1:0]            cnt_q;
    logic [CONTROL_WIDTH-1:0] op_q;
    logic                     zpend_q;
    // hi_q: product high word / partial remainder
    // lo_q: multiplier being shifted out / dividend shifting into quotient
    // m_q : multiplicand / divisor
    logic [DATA_WIDTH-1:0]    hi_q;
    logic [DATA_WIDTH-1:0]    lo_q;
    logic [DATA_WIDTH-1:0]    m_q;
    logic [DATA_WIDTH-1:0]    hi_d;
    logic [DATA_WIDTH-1:0]    lo_d;
    logic [DATA_WIDTH-1:0]    iter_res;
    logic [DATA_WIDTH:0]      mul_sum;
    logic [DATA_WIDTH:0]      div_rs;
    logic [DATA_WIDTH+1:0]    div_diff;
    logic                     div_borrow;
    logic                     is_mul;

    assign iter_op = (ALUctrl_i == OP_MUL) || (ALUctrl_i == OP_MULHU) ||
                     (ALUctrl_i == OP_DIVU) || (ALUctrl_i == OP_REMU);
    assign is_mul  = (op_q == OP_MUL) || (op_q == OP_MULHU);

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(DATA_WIDTH+1){1'b0}});
        div_rs     = {hi_q, lo_q[DATA_WIDTH-1]};
        div_diff   = {1'b0, div_rs} - {2'b00, m_q};
        div_borrow = div_diff[DATA_WIDTH+1];
        if (is_mul) begin
            hi_d = mul_sum[DATA_WIDTH:1];
            lo_d = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
        end else begin
            // Divisor zero never borrows, so the quotient fills with ones
            // and the dividend ends up in the remainder.
            hi_d = div_borrow ? div_rs[DATA_WIDTH-1:0] : div_diff[DATA_WIDTH-1:0];
            lo_d = {lo_q[DATA_WIDTH-2:0], ~div_borrow};
        end
        case (op_q)
            OP_MULHU, OP_REMU: iter_res = hi_d;
            default:           iter_res = lo_d;
        endcase
    end

    // Iterative datapath: load operands on accept, step while busy.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_q    <= ALUctrl_i;
            zpend_q <= (SrcA_i == SrcB_i);
            hi_q    <= '0;
            if ((ALUctrl_i == OP_MUL) || (ALUctrl_i == OP_MULHU)) begin
                lo_q <= SrcB_i;
                m_q  <= SrcA_i;
            end else begin
                lo_q <= SrcA_i;
                m_q  <= SrcB_i;
            end
        end else if (state_q == BUSY) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Control FSM with registered result, zero flag and valid pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= iter_res;
                        zero_q   <= zpend_q;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    if (accept && iter_op) begin
                        state_q <= BUSY;
                        cnt_q   <= CW'(DATA_WIDTH-1);
                        valid_q <= 1'b0;
                    end else if (accept) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        result_q <= alu_comb(ALUctrl_i, SrcA_i, SrcB_i);
                        zero_q   <= (SrcA_i == SrcB_i);
                    end else begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end
`else
    assign iter_op = 1'b0;

    // Control FSM; without the iterative datapath BUSY is never entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else if (accept && !iter_op) begin
            state_q  <= DONE;
            valid_q  <= 1'b1;
            result_q <= alu_comb(ALUctrl_i, SrcA_i, SrcB_i);
            zero_q   <= (SrcA_i == SrcB_i);
        end else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (DATA_WIDTH = 32).
module tb_alu_seq;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic [3:0]  ALUctrl_i;
    logic [31:0] SrcA_i;
    logic [31:0] SrcB_i;
    logic        valid_o;
    logic [31:0] ALUResult_o;
    logic        Zero_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_res;

    alu_seq #(.DATA_WIDTH(32), .CONTROL_WIDTH(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .flush_i     (flush_i),
        .ALUctrl_i   (ALUctrl_i),
        .SrcA_i      (SrcA_i),
        .SrcB_i      (SrcB_i),
        .valid_o     (valid_o),
        .ALUResult_o (ALUResult_o),
        .Zero_o      (Zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_i   = 1'b1;
        ALUctrl_i = op;
        SrcA_i    = a;
        SrcB_i    = b;
    endtask

    // One single-cycle op: accept, then check the pulse one cycle later.
    task automatic op1(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic expz);
        drive(op, a, b);
        tick();
        valid_i = 1'b0;
        chk({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
        chk({tag, ".res"}, ALUResult_o, exp);
        chk({tag, ".zero"}, {31'd0, Zero_o}, {31'd0, expz});
        last_res = exp;
    endtask

    // Iterative op: count busy cycles (bounded), then check the result pulse.
    task automatic opi(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic expz);
        int n;
        int early;
        logic [31:0] e;
        n     = 0;
        early = 0;
        e     = MD ? exp : 32'd0;
        drive(op, a, b);
        tick();
        valid_i = 1'b0;
        while (!ready_o && n < 100) begin
            if (valid_o) early++;
            n++;
            tick();
        end
        chk({tag, ".busy"}, n, MD ? 32'd32 : 32'd0);
        chk({tag, ".early"}, early, 32'd0);
        chk({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
        chk({tag, ".res"}, ALUResult_o, e);
        chk({tag, ".zero"}, {31'd0, Zero_o}, {31'd0, expz});
        last_res = e;
    endtask

    initial begin
        int pulses;
        rst_ni    = 1'b1;
        valid_i   = 1'b0;
        flush_i   = 1'b0;
        ALUctrl_i = 4'h0;
        SrcA_i    = '0;
        SrcB_i    = '0;
        last_res  = '0;
        #1 rst_ni = 1'b0;
        tick();
        tick();
        chk("rst.ready", {31'd0, ready_o}, 32'd1);
        chk("rst.valid", {31'd0, valid_o}, 32'd0);
        chk("rst.res", ALUResult_o, 32'd0);
        chk("rst.zero", {31'd0, Zero_o}, 32'd0);
        rst_ni = 1'b1;
        tick();

        // ADD then SUB back-to-back
        drive(4'h0, 32'd5, 32'd7);
        tick();
        chk("add.valid", {31'd0, valid_o}, 32'd1);
        chk("add.res", ALUResult_o, 32'd12);
        chk("add.zero", {31'd0, Zero_o}, 32'd0);
        chk("add.ready", {31'd0, ready_o}, 32'd1);
        drive(4'h1, 32'h1234, 32'h1234);
        tick();
        valid_i = 1'b0;
        chk("sub.valid", {31'd0, valid_o}, 32'd1);
        chk("sub.res", ALUResult_o, 32'd0);
        chk("sub.zero", {31'd0, Zero_o}, 32'd1);
        chk("sub.ready", {31'd0, ready_o}, 32'd1);
        tick();
        chk("idle.valid", {31'd0, valid_o}, 32'd0);
        chk("idle.hold", {31'd0, Zero_o}, 32'd1);

        op1("sra",   4'h8, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0);
        op1("slt",   4'h9, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0);
        op1("sltu",  4'hA, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
        op1("xor",   4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
        op1("srl",   4'h6, 32'h8000_0000, 32'h24,        32'h0800_0000, 1'b0);
        op1("sll",   4'h5, 32'd1,         32'd31,        32'h8000_0000, 1'b0);
        op1("and",   4'h2, 32'hFF00_0F0F, 32'h0FF0_00FF, 32'h0F00_000F, 1'b0);
        op1("or",    4'h3, 32'hFF00_0000, 32'h0000_00F1, 32'hFF00_00F1, 1'b0);
        op1("passb", 4'h7, 32'd3,         32'hCAFE_0001, 32'hCAFE_0001, 1'b0);
        op1("subw",  4'h1, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0);
        op1("rsvd",  4'hF, 32'd5,         32'd5,         32'd0,         1'b1);
        tick();

        opi("mul",   4'hB, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0);
        opi("mulhu", 4'hC, 32'hFFFF_FFFF, 32'd2, 32'd1,         1'b0);
        opi("mulsq", 4'hB, 32'd3,         32'd3, 32'd9,         1'b1);
        opi("divu",  4'hD, 32'd100,       32'd7, 32'd14,        1'b0);
        opi("remu",  4'hE, 32'd100,       32'd7, 32'd2,         1'b0);
        opi("div0",  4'hD, 32'd9,         32'd0, 32'hFFFF_FFFF, 1'b0);
        opi("rem0",  4'hE, 32'd9,         32'd0, 32'd9,         1'b0);
        tick();

        // Flush at busy cycle 10
        drive(4'hB, 32'd1234, 32'd5678);
        tick();
        valid_i = 1'b0;
        if (MD) last_res = 32'd9;
        for (int i = 0; i < 9; i++) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush.valid", {31'd0, valid_o}, 32'd0);
        chk("flush.ready", {31'd0, ready_o}, 32'd1);
        chk("flush.hold", ALUResult_o, last_res);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) pulses++;
            tick();
        end
        chk("flush.nopulse", pulses, 32'd0);

        // Flush beats a coincident accept
        drive(4'h0, 32'd1, 32'd1);
        flush_i = 1'b1;
        tick();
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flushacc.valid", {31'd0, valid_o}, 32'd0);
        chk("flushacc.hold", ALUResult_o, last_res);

        // Reset at busy cycle 10
        drive(4'hB, 32'hFFFF_FFFF, 32'd2);
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst_ni = 1'b0;
        #1;
        chk("rstb.res", ALUResult_o, 32'd0);
        chk("rstb.valid", {31'd0, valid_o}, 32'd0);
        tick();
        chk("rstb.ready", {31'd0, ready_o}, 32'd1);
        rst_ni = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) pulses++;
            tick();
        end
        chk("rstb.nopulse", pulses, 32'd0);
        chk("rstb.res2", ALUResult_o, 32'd0);

        // Still functional after the abort
        op1("post", 4'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
